// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: streams sequential words from instruction RAM into a
// small PC-tagged FIFO feeding decode; a redirect flushes and restarts fetch.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              out_fault
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             pend_q, pend_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic             fault_mem [DEPTH];

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [31:0]      wr_instr;
  logic [31:0]      wr_pc;
  logic             wr_fault;
  logic             push;
  logic             pop;

  assign mem_addr  = fetch_pc_q[ADDR_W-1:0];
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign out_fault = out_valid ? fault_mem[rd_ptr_q] : 1'b0;

  // An in-flight fetch reserves a slot, so the FIFO can never overflow.
  assign mem_req = resetn && !halted_q && !redirect_valid &&
                   ((int'(count_q) + int'(pend_q)) < DEPTH);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    halted_d   = halted_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_en      = 1'b0;
    wr_idx     = wr_ptr_q;
    wr_instr   = mem_data;
    wr_pc      = pend_pc_q;
    wr_fault   = 1'b0;
    push       = pend_q && !redirect_valid;
    pop        = out_valid && out_ready && !redirect_valid;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      if (redirect_pc[1:0] != 2'b00) begin
        // Misaligned target: queue a lone fault marker and stop fetching.
        halted_d = 1'b1;
        wr_en    = 1'b1;
        wr_idx   = '0;
        wr_instr = 32'h0;
        wr_pc    = redirect_pc;
        wr_fault = 1'b1;
        wr_ptr_d = PTR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        halted_d = 1'b0;
        wr_ptr_d = '0;
        count_d  = '0;
      end
    end else begin
      if (mem_req) begin
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
      halted_q   <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is not cleared; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      instr_mem[wr_idx] <= wr_instr;
      pc_mem[wr_idx]    <= wr_pc;
      fault_mem[wr_idx] <= wr_fault;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 14;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              resetn, redirect_valid, out_ready;
  logic [31:0]       redirect_pc, mem_data;
  logic              mem_req, out_valid, out_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       out_instr, out_pc;

  ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:4095];
  always @(posedge clk) mem_data <= ram[mem_addr[13:2]];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fetch = 32'h0, m_pend_pc = 32'h0;
  bit          m_pend = 0, m_halted = 0, m_known = 0;

  int checks = 0, passed = 0;
  logic        s_req, s_valid, s_fault;
  logic [31:0] s_pc, s_instr;
  logic [13:0] s_addr;
  logic [31:0] boot_w [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One cycle: compare outputs to the model, advance the model, wait for the next negedge.
  task automatic step();
    bit   e_req;
    ent_t e;
    #1;
    s_req = mem_req; s_addr = mem_addr; s_valid = out_valid;
    s_pc = out_pc; s_instr = out_instr; s_fault = out_fault;
    e_req = resetn && !m_halted && !redirect_valid && ((mq.size() + int'(m_pend)) < DEPTH);
    chk("mem_req", s_req, e_req);
    if (m_known) begin
      chk("mem_addr", s_addr, m_fetch[13:0]);
      chk("out_valid", s_valid, mq.size() > 0);
      if (mq.size() > 0) e = mq[0];
      else e = '{32'h0, 32'h0, 1'b0};
      chk("out_pc", s_pc, e.pc);
      chk("out_instr", s_instr, e.instr);
      chk("out_fault", s_fault, e.fault);
    end
    if (!resetn) begin
      m_fetch = RESET_PC; m_pend = 0; m_halted = 0; mq.delete(); m_known = 1;
    end else if (redirect_valid) begin
      mq.delete();
      m_pend   = 0;
      m_fetch  = redirect_pc;
      m_halted = (redirect_pc[1:0] != 2'b00);
      if (m_halted) mq.push_back(ent_t'{32'h0, redirect_pc, 1'b1});
    end else begin
      if (mq.size() > 0 && out_ready) mq.delete(0);
      if (m_pend) mq.push_back(ent_t'{ram[m_pend_pc[13:2]], m_pend_pc, 1'b0});
      m_pend = e_req;
      if (e_req) begin
        m_pend_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  // Expected start-up stream after resetn rises with out_ready held high.
  task automatic boot_check();
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin
        chk("boot_req0", s_req, 1'b1);
        chk("boot_addr0", s_addr, 32'h0);
        chk("boot_valid0", s_valid, 1'b0);
      end
      if (c == 1) chk("boot_addr1", s_addr, 32'h4);
      if (c >= 2) begin
        chk("boot_valid", s_valid, 1'b1);
        chk("boot_pc", s_pc, RESET_PC + 32'(4 * (c - 2)));
        chk("boot_instr", s_instr, boot_w[c-2]);
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) ram[i] = 32'hC0DE_0000 + 32'(i);
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
    boot_w[0] = 32'h11; boot_w[1] = 32'h22; boot_w[2] = 32'h33; boot_w[3] = 32'h44;

    resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    step();
    step();
    resetn = 1'b1;
    boot_check();

    // Stall from empty: four fetches fill the queue, then nothing until a pop.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040; out_ready = 1'b0;
    step();
    chk("redir_req", s_req, 1'b0);
    redirect_valid = 1'b0;
    n = 0;
    repeat (10) begin step(); n += int'(s_req); end
    chk("stall_req_count", n, 4);
    chk("stall_full_valid", s_valid, 1'b1);
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r == 4) out_ready = 1'b0;
      step();
      chk("drain_valid", s_valid, 1'b1);
      chk("drain_pc", s_pc, 32'h8000_0040 + 32'(4 * r));
      if (r == 0) chk("drain_req0", s_req, 1'b0);
      if (r == 1) chk("drain_req1", s_req, 1'b1);
      if (r == 4) chk("drain_instr4", s_instr, 32'hC0DE_0014);
    end

    // Flush with three entries queued and one in flight.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; out_ready = 1'b1;
    step();
    chk("flush_req", s_req, 1'b0);
    redirect_valid = 1'b0;
    step();
    chk("flush_valid1", s_valid, 1'b0);
    chk("flush_req1", s_req, 1'b1);
    chk("flush_addr1", s_addr, 32'h0100);
    step();
    chk("flush_valid2", s_valid, 1'b0);
    step();
    chk("flush_valid3", s_valid, 1'b1);
    chk("flush_pc3", s_pc, 32'h8000_0100);
    chk("flush_instr3", s_instr, 32'hC0DE_0040);
    repeat (3) step();

    // Misaligned redirect: one fault marker, then silence.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    step();
    chk("fault_valid", s_valid, 1'b1);
    chk("fault_flag", s_fault, 1'b1);
    chk("fault_pc", s_pc, 32'h8000_0102);
    chk("fault_instr", s_instr, 32'h0);
    chk("fault_req", s_req, 1'b0);
    n = 0;
    repeat (20) begin step(); n += int'(s_req); end
    chk("halt_req_count", n, 0);
    chk("halt_valid", s_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    step();
    chk("resume_req", s_req, 1'b1);
    chk("resume_addr", s_addr, 32'h0200);
    step();
    step();
    chk("resume_valid", s_valid, 1'b1);
    chk("resume_pc", s_pc, 32'h8000_0200);
    chk("resume_fault", s_fault, 1'b0);

    // PC wrap at the top of the 32-bit space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_addr0", s_addr, 32'h3FF8);
    step();
    chk("wrap_addr1", s_addr, 32'h3FFC);
    step();
    chk("wrap_addr2", s_addr, 32'h0000);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", s_pc, 32'h0000_0000);
    chk("wrap_valid2", s_valid, 1'b1);

    // Reset coinciding with a redirect while the queue is full.
    out_ready = 1'b0;
    repeat (6) step();
    chk("prereset_valid", s_valid, 1'b1);
    resetn = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    chk("reset_req", s_req, 1'b0);
    resetn = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    boot_check();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
